// File: rtl/dmem_bridge_pkg.sv
// Shared types and helpers for the core-to-bus data-memory bridge.
// Holds the FSM encoding, the load/store size codes and the access-legality checks.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // funct3[1:0] carries the access size: 00 byte, 01 half, anything else word.
    function automatic logic f_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic r;
        case (funct3[1:0])
            2'b00:   r = 1'b0;
            2'b01:   r = addr_lo[0];
            default: r = |addr_lo;
        endcase
        return r;
    endfunction

    function automatic logic f_load_legal(input logic [2:0] funct3);
        return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
               (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

    function automatic logic [31:0] f_store_data(input logic [2:0] funct3, input logic [31:0] wdata);
        logic [31:0] r;
        case (funct3[1:0])
            2'b00:   r = {4{wdata[7:0]}};
            2'b01:   r = {2{wdata[15:0]}};
            default: r = wdata;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] f_store_strb(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [3:0] r;
        case (funct3[1:0])
            2'b00:   r = 4'b0001 << addr_lo;
            2'b01:   r = 4'b0011 << addr_lo;
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// External valid/ready data bus between the bridge (master) and memory (slave).
interface dmem_bridge_if;
    logic        valid;
    logic        ready;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (
        output valid, wr, addr, wdata, strb,
        input  ready, rdata, rvalid
    );

    modport slave (
        input  valid, wr, addr, wdata, strb,
        output ready, rdata, rvalid
    );
endinterface

// File: rtl/dmem_bridge_load_align.sv
// Extracts the addressed byte/half from a bus read word and sign- or zero-extends it.
module load_align
    import dmem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [31:0] w_lane;

    assign w_lane = rdata_i >> {addr_i, 3'b000};

    always_comb begin
        result_o = '0;
        case (funct3_i)
            F3_B:    result_o = {{24{w_lane[7]}}, w_lane[7:0]};
            F3_H:    result_o = {{16{w_lane[15]}}, w_lane[15:0]};
            F3_W:    result_o = w_lane;
            F3_BU:   result_o = {24'h0, w_lane[7:0]};
            F3_HU:   result_o = {16'h0, w_lane[15:0]};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// Core data-port to valid/ready bus bridge: word-aligns accesses, stalls the core while
// a transaction is in flight, and reports misaligned/illegal accesses and bus timeouts.
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_rd_i,
    input  logic                 req_wr_i,
    input  logic [31:0]          req_addr_i,
    input  logic [31:0]          req_wdata_i,
    input  logic [2:0]           req_funct3_i,
    output logic [31:0]          rdata_o,
    output logic                 stall_o,
    output logic                 err_o,
    dmem_bridge_if.master        bus
);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_tmo_cnt;
    logic [CNT_W-1:0]   w_tmo_next;
    logic [1:0]         r_addr_lo;
    logic [2:0]         r_funct3;
    logic               r_bus_valid, w_bus_valid_next;
    logic               r_bus_wr,    w_bus_wr_next;
    logic [31:0]        r_bus_addr,  w_bus_addr_next;
    logic [31:0]        r_bus_wdata, w_bus_wdata_next;
    logic [3:0]         r_bus_strb,  w_bus_strb_next;
    logic [31:0]        r_rdata,     w_rdata_next;
    logic               r_err,       w_err_next;

    logic               w_active;
    logic               w_capture;
    logic               w_reject;
    logic               w_tmo_hit;
    logic [31:0]        w_load_data;

    assign w_active  = req_rd_i | req_wr_i;
    assign w_capture = (r_state == IDLE) && w_active;
    // A simultaneous rd+wr is treated as a store, so only loads face the funct3 legality check.
    assign w_reject  = f_misaligned(req_funct3_i, req_addr_i[1:0]) ||
                       (!req_wr_i && !f_load_legal(req_funct3_i));
    assign w_tmo_hit = (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    load_align u_load_align (
        .rdata_i  (bus.rdata),
        .addr_i   (r_addr_lo),
        .funct3_i (r_funct3),
        .result_o (w_load_data)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_tmo_cnt   <= '0;
            r_addr_lo   <= '0;
            r_funct3    <= '0;
            r_bus_valid <= 1'b0;
            r_bus_wr    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_strb  <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_tmo_cnt   <= w_tmo_next;
            r_bus_valid <= w_bus_valid_next;
            r_bus_wr    <= w_bus_wr_next;
            r_bus_addr  <= w_bus_addr_next;
            r_bus_wdata <= w_bus_wdata_next;
            r_bus_strb  <= w_bus_strb_next;
            r_rdata     <= w_rdata_next;
            r_err       <= w_err_next;
            if (w_capture) begin
                r_addr_lo <= req_addr_i[1:0];
                r_funct3  <= req_funct3_i;
            end
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_tmo_next       = r_tmo_cnt;
        w_bus_valid_next = r_bus_valid;
        w_bus_wr_next    = r_bus_wr;
        w_bus_addr_next  = r_bus_addr;
        w_bus_wdata_next = r_bus_wdata;
        w_bus_strb_next  = r_bus_strb;
        w_rdata_next     = r_rdata;
        w_err_next       = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_active) begin
                    if (w_reject) begin
                        w_state_next = DONE;
                        w_err_next   = 1'b1;
                        w_rdata_next = '0;
                    end else begin
                        w_state_next     = REQ;
                        w_tmo_next       = '0;
                        w_bus_valid_next = 1'b1;
                        w_bus_wr_next    = req_wr_i;
                        w_bus_addr_next  = {req_addr_i[31:2], 2'b00};
                        w_bus_wdata_next = req_wr_i ? f_store_data(req_funct3_i, req_wdata_i) : '0;
                        w_bus_strb_next  = req_wr_i ? f_store_strb(req_funct3_i, req_addr_i[1:0]) : 4'b0000;
                    end
                end
            end

            REQ: begin
                // Only a write acceptance completes the access; a read acceptance cannot rescue the last cycle.
                if (bus.ready && r_bus_wr) begin
                    w_bus_valid_next = 1'b0;
                    w_state_next     = DONE;
                end else if (w_tmo_hit) begin
                    w_bus_valid_next = 1'b0;
                    w_state_next     = DONE;
                    w_err_next       = 1'b1;
                    w_rdata_next     = '0;
                end else begin
                    w_tmo_next = r_tmo_cnt + CNT_W'(1);
                    if (bus.ready) begin
                        w_bus_valid_next = 1'b0;
                        w_state_next     = WAIT_R;
                    end
                end
            end

            WAIT_R: begin
                if (bus.rvalid) begin
                    w_rdata_next = w_load_data;
                    w_state_next = DONE;
                end else if (w_tmo_hit) begin
                    w_state_next = DONE;
                    w_err_next   = 1'b1;
                    w_rdata_next = '0;
                end else begin
                    w_tmo_next = r_tmo_cnt + CNT_W'(1);
                end
            end

            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign stall_o   = w_active && (r_state != DONE);
    assign err_o     = r_err;
    assign rdata_o   = r_rdata;
    assign bus.valid = r_bus_valid;
    assign bus.wr    = r_bus_wr;
    assign bus.addr  = r_bus_addr;
    assign bus.wdata = r_bus_wdata;
    assign bus.strb  = r_bus_strb;

endmodule
